// File: rtl/mc_alu_pkg.sv
// Shared types for mc_alu: opcode and FSM enums plus opcode-class helpers.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND   = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_SLL  = 4'b0101, OP_SRL   = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL   = 4'b1010, OP_MULHU = 4'b1011,
    OP_DIV  = 4'b1100, OP_DIVU = 4'b1101, OP_REM   = 4'b1110, OP_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  // Opcode classes are decoded from the upper opcode bits.
  localparam logic [2:0] CLS_MUL = 3'b101;
  localparam logic [1:0] CLS_DIV = 2'b11;

  function automatic logic is_mul_op(input alu_op_e op);
    return 3'(op >> 1) == CLS_MUL;
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return 2'(op >> 2) == CLS_DIV;
  endfunction

endpackage

// File: rtl/mc_alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
module mc_alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d;
  logic [XLEN:0]   rem_sh;
  logic            ge, busy_q;
  logic [CW-1:0]   cnt_q;

  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign rem_d  = ge ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
  assign quo_d  = {quo_q[XLEN-2:0], ge};

  // done_o marks the final iteration; the outputs carry that step's result
  // so the owner can register it on the same edge.
  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CW'(XLEN-1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic ops, shift-add multiplier, optional
// divider built only when MC_ALU_DIV_EN is defined.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [3:0]      ALUoperation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);
  localparam int CW = $clog2(XLEN);

  state_e            state_q, state_d;
  alu_op_e           op_in, op_q;
  logic              accept, mul_last, load_res, err_d, zero_q, err_q;
  logic [XLEN-1:0]   mcand_q, result_q, res_d, alu_res;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     psum;
  logic [CW-1:0]     cnt_q;

  assign op_in    = alu_op_e'(ALUoperation);
  assign accept   = in_valid && in_ready;
  assign mul_last = cnt_q == CW'(XLEN-1);

  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = operand1 + operand2;
      OP_SUB:  alu_res = operand1 - operand2;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_SLL:  alu_res = operand1 << operand2[SHAMT_W-1:0];
      OP_SRL:  alu_res = operand1 >> operand2[SHAMT_W-1:0];
      OP_SRA:  alu_res = $signed(operand1) >>> operand2[SHAMT_W-1:0];
      OP_SLT:  alu_res = XLEN'($signed(operand1) < $signed(operand2));
      OP_SLTU: alu_res = XLEN'(operand1 < operand2);
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: the multiplier sits in the low half and shifts out
  // as the partial product grows into the high half.
  assign psum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d = {psum, prod_q[XLEN-1:1]};

`ifdef MC_ALU_DIV_EN
  logic [XLEN-1:0] a_q, b_q, div_q, div_r, dvd_in, dvs_in, q_fix, r_fix, div_res;
  logic            sgn_in, sgn_q, quo_sel, div_busy, div_done;

  assign sgn_in = (op_in == OP_DIV) || (op_in == OP_REM);
  assign dvd_in = (sgn_in && operand1[XLEN-1]) ? -operand1 : operand1;
  assign dvs_in = (sgn_in && operand2[XLEN-1]) ? -operand2 : operand2;

  mc_alu_divider #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (accept && is_div_op(op_in)),
    .dividend_i  (dvd_in),
    .divisor_i   (dvs_in),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  // Magnitudes are divided; signs are restored here. MIN/-1 falls out
  // naturally since -MIN wraps back to MIN.
  assign sgn_q   = (op_q == OP_DIV) || (op_q == OP_REM);
  assign quo_sel = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign q_fix   = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_q : div_q;
  assign r_fix   = (sgn_q && a_q[XLEN-1]) ? -div_r : div_r;

  always_comb begin
    if (b_q == '0) div_res = quo_sel ? '1 : a_q;
    else           div_res = quo_sel ? q_fix : r_fix;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (is_mul_op(op_in))      state_d = ST_MUL;
`ifdef MC_ALU_DIV_EN
        else if (is_div_op(op_in)) state_d = ST_DIV;
`endif
        else                       state_d = ST_DONE;
      end
      ST_MUL:  if (mul_last)  state_d = ST_DONE;
`ifdef MC_ALU_DIV_EN
      ST_DIV:  if (div_done)  state_d = ST_DONE;
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef MC_ALU_DIV_EN
    in_ready  = (state_q == ST_IDLE) && !div_busy;
`else
    in_ready  = state_q == ST_IDLE;
`endif
    out_valid = state_q == ST_DONE;
  end

  always_comb begin
    load_res = 1'b0;
    res_d    = alu_res;
    err_d    = 1'b0;
    if (accept && !is_mul_op(op_in)) begin
`ifdef MC_ALU_DIV_EN
      load_res = !is_div_op(op_in);
`else
      load_res = 1'b1;
      err_d    = is_div_op(op_in);
`endif
    end else if (state_q == ST_MUL && mul_last) begin
      load_res = 1'b1;
      res_d    = (op_q == OP_MULHU) ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
    end
`ifdef MC_ALU_DIV_EN
    else if (state_q == ST_DIV && div_done) begin
      load_res = 1'b1;
      res_d    = div_res;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
`ifdef MC_ALU_DIV_EN
      a_q      <= '0;
      b_q      <= '0;
`endif
    end else begin
      if (accept) begin
        op_q    <= op_in;
        mcand_q <= operand2;
        prod_q  <= {{XLEN{1'b0}}, operand1};
        cnt_q   <= '0;
`ifdef MC_ALU_DIV_EN
        a_q     <= operand1;
        b_q     <= operand2;
`endif
      end else if (state_q == ST_MUL) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CW'(1);
      end
      if (load_res) begin
        result_q <= res_d;
        zero_q   <= res_d == '0;
        err_q    <= err_d;
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), shift-amount bits taken from operand2 LSBs.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request presented.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 operand1, operand2  input  XLEN  source operands.
REQ-008 ALUoperation  input  4  opcode, sampled on accept.
REQ-009 out_valid  output  1  result/zero/err valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  high when result == 0, registered with result.
REQ-013 err  output  1  high when the completed op is unsupported in this build.

Function
REQ-014 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-015 Accept = in_valid && in_ready; in_ready high only in state IDLE.
REQ-016 States IDLE, MUL, DIV, DONE; IDLE->DONE for opcodes 0000-1001, IDLE->MUL for 1010/1011, IDLE->DIV for 1100-1111.
REQ-017 Opcodes 0000-1001 SHALL present out_valid the cycle after accept (latency 1).
REQ-018 MUL/DIV SHALL iterate one bit per cycle, leaving MUL/DIV after exactly XLEN cycles; out_valid asserts XLEN+1 cycles after accept.
REQ-019 DONE holds out_valid, result, zero, err stable until out_ready; on out_valid && out_ready go to IDLE; out_ready while not out_valid is ignored.
REQ-020 No back-to-back accept: a new request is accepted no earlier than the cycle after the handshake completes.
REQ-021 Arithmetic wraps modulo 2^XLEN; SLT/SLTU result is zero-extended 0 or 1.
REQ-022 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU result = operand1; takes full XLEN cycles.
REQ-023 Signed overflow (operand1 = most-negative, operand2 = -1): DIV result = operand1, REM result = 0.
REQ-024 DIV/REM signs: quotient truncates toward zero, remainder takes the sign of operand1.
REQ-025 Operands and opcode are captured on accept; input changes afterwards SHALL not affect the result.
REQ-026 err is 0 for every supported opcode.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, zero 1, err 0, iteration counter 0.
REQ-028 Reset mid-MUL/DIV SHALL abandon the operation; no out_valid follows it.
REQ-029 in_ready SHALL be 1 the first cycle after reset release.

Configuration
REQ-030 Macro MC_ALU_DIV_EN: when defined, the DIV state and divider are built, giving REQ-018/022/023/024 behaviour.
REQ-031 When MC_ALU_DIV_EN is undefined, opcodes 1100-1111 SHALL go IDLE->DONE with latency 1, result 0, zero 1, err 1; no divider logic instantiated.

Structure
REQ-032 Package mc_alu_pkg SHALL hold the opcode enum (4-bit), the state enum and opcode-class helper constants.
REQ-033 Sub-module mc_alu_divider SHALL implement the iterative restoring unsigned divider (start, busy, done, quotient, remainder); sign fix-up stays in mc_alu.

Verification
REQ-034 XLEN=32: ADD 10+20 -> result 30, zero 0, out_valid 1 cycle after accept; SUB 10-10 -> 0, zero 1.
REQ-035 SRA 0xF0000000 by 4 -> 0xFF000000; SLT -5<10 -> 1; SLTU 0xFFFFFFF0<0x10 -> 0.
REQ-036 MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same -> 0x00000001; out_valid exactly 33 cycles after accept.
REQ-037 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
REQ-038 out_ready held low 5 cycles after ADD completes -> result stable, in_ready 0 throughout; rst_n pulsed mid-DIV -> out_valid never asserts, in_ready 1 after release.
REQ-039 Build without MC_ALU_DIV_EN: DIV 8/2 -> result 0, err 1, latency 1.
